tone_synth: RTL and testbench
=============================

// Module: tone_synth
// PURPOSE
//  Downstream audio stage of the beat counter. Per beat, the music ROM supplies a half-period divider per channel.
//  tone_synth turns those dividers into square waves, applies a volume level and a 16-step attack/release envelope,
//  and drives signed 16-bit left/right samples to the audio serializer.
// PARAMETERS
//  ENV_STEP  2048  clk cycles per envelope step (must be >=1)
//  DIV_W     22    width of note divider inputs
// PORTS
//  clk         in   1      system clock (single clock domain)
//  reset_n     in   1      asynchronous, active-low reset
//  mode        in   4      game mode (GAMESTART=0..FAILURE=5), same encoding as beat counter
//  ibeat       in   12     current beat index from beat counter
//  note_div_l  in   DIV_W  left half-period in clk cycles; <2 = rest
//  note_div_r  in   DIV_W  right half-period in clk cycles; <2 = rest
//  volume      in   3      volume level 0..7
//  mute        in   1      1 = release envelope to silence
//  audio_l     out  16     signed left sample
//  audio_r     out  16     signed right sample
//  note_on     out  1      1 while envelope not IDLE
// BEHAVIOUR
//  Reset: audio_l=audio_r=0, note_on=0, env=0, state IDLE, osc counters/phase=0, ibeat_q=0, mode_q=0.
//  Oscillator (per channel):
//   - Counter runs 0..div_act-1, then wraps and toggles phase.
//   - div_act latches note_div at each wrap (glitch-free change).
//   - While div_act<2, counter and phase are held 0.
//   - When idle in rest, a new div>=2 loads div_act immediately.
//  Retrigger: ibeat!=ibeat_q and note_div_l differs from div latched at last retrigger -> ATTACK from env=0.
//   Osc counters/phase reset the same cycle. Same-note beat changes are tied (no retrigger).
//  Mode change (mode!=mode_q): same as retrigger, unconditionally.
//  Envelope FSM, env 5-bit 0..16, one step per ENV_STEP cycles (step timer restarts on every transition):
//   - IDLE: env=0 -> ATTACK on retrigger/mode change while mute=0.
//   - ATTACK: env+1 per step -> SUSTAIN at 16.
//   - SUSTAIN: hold 16.
//   - RELEASE: env-1 per step -> IDLE at 0.
//   - mute=1 in any non-IDLE state -> RELEASE.
//   - mute falling during RELEASE -> ATTACK from current env.
//  Simultaneous events: mute and retrigger in same cycle -> mute wins (RELEASE, or stay IDLE).
//  Arithmetic:
//   - amp = (VOL_TBL[volume]*env)>>4; VOL_TBL = {0,0x0800,0x1000,...,0x3800} (step 0x0800); max 0x3800, no overflow.
//   - sample = phase ? +amp : -amp; rest channel -> 0.
//  Latency: outputs registered; 1 cycle after phase/env/volume change.
//  Invalid mode (>5): outputs 0, FSM forced IDLE, osc held 0.
//  reset_n low mid-note: immediate async clear to reset values.
// CONFIGURATION
//  TONE_SYNTH_STEREO_EN defined: independent right oscillator from note_div_r.
//  Not defined: note_div_r ignored; audio_r = audio_l (same cycle); only one oscillator instantiated.
// STRUCTURE
//  audio_pkg: mode constants (GAMESTART..FAILURE), VOL_TBL, envelope state encoding, ENV_MAX=16.
//  Sub-module square_osc (counter, div latch, phase); one per channel; FSM/scaling in tone_synth.
// TESTING (ENV_STEP=4 for all)
//  1. mode=1, ibeat 0->1, div_l=5, vol=7, mute=0:
//     -> phase toggles every 5 clk; env reaches 16 after 64 clk; audio_l = +/-0x3800.
//  2. ibeat 1->2, div_l unchanged -> no retrigger, env stays 16; then div_l=3 at ibeat 3
//     -> env restarts at 0, osc phase 0.
//  3. In SUSTAIN assert mute -> env 16..0 over 64 clk, note_on falls, audio 0.
//     Same-cycle mute+retrigger from IDLE -> stays IDLE.
//  4. div_l=1 (rest) -> audio_l=0 and counter held.
//     Change div 5->9 mid-period -> current half-period completes at 5, next is 9.
//  5. mode 2->5 mid-note -> osc phase reset, env from 0.
//     mode=7 -> outputs 0 next cycle.
//     reset_n pulse mid-note -> all outputs 0 asynchronously.
//  6. With TONE_SYNTH_STEREO_EN: div_l=5, div_r=7 -> independent periods.
//     Without: audio_r==audio_l every cycle.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared constants and helpers for the tone synthesizer.
//                Includes game mode encodings, the volume table, envelope
//                state encoding and sample-scaling functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Game mode encoding, shared with the beat counter
    localparam logic [3:0] GAMESTART = 4'd0;
    localparam logic [3:0] PLAYING   = 4'd1;
    localparam logic [3:0] PAUSED    = 4'd2;
    localparam logic [3:0] LEVELUP   = 4'd3;
    localparam logic [3:0] SUCCESS   = 4'd4;
    localparam logic [3:0] FAILURE   = 4'd5;

    // Envelope full-scale value (16 steps)
    localparam logic [4:0] ENV_MAX = 5'd16;

    // Peak amplitude per volume level, in steps of 0x0800.
    // Element 0 is the rightmost entry.
    localparam logic [7:0][15:0] VOL_TBL = {
        16'h3800, 16'h3000, 16'h2800, 16'h2000,
        16'h1800, 16'h1000, 16'h0800, 16'h0000
    };

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

    // Computes (VOL_TBL[vol] * env) >> 4. The peak result is 0x3800, so
    // the value always fits in 16 bits without overflow.
    function automatic logic [15:0] env_scale(input logic [2:0] vol, input logic [4:0] env);
        logic [19:0] prod;
        prod = 20'(VOL_TBL[vol]) * 20'(env);
        return 16'(prod >> 4);
    endfunction

    // Returns +amp when phase is high and -amp otherwise.
    // Returns 0 for silent channels.
    function automatic logic signed [15:0] square_sample(input logic [15:0] amp,
                                                         input logic        phase,
                                                         input logic        silent);
        logic signed [15:0] s;
        s = signed'(amp);
        if (silent) begin
            s = '0;
        end else if (!phase) begin
            s = -s;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/square_osc.sv
`default_nettype none
// ============================================================================
//  Module      : square_osc
//  Description : Half-period square-wave oscillator. The divider value is
//                latched only when the counter wraps, so a new note begins
//                without a glitch. Divider values below 2 mean "rest".
//  Revision    : 1.0 - initial release
// ============================================================================
module square_osc #(
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             clear,     // restart the oscillator with the current div
    output logic             phase,
    output logic             rest
);

    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_rest;
    logic             w_wrap;

    // A latched divider below 2 means rest. Zero and one differ only in bit 0.
    assign w_rest = (r_div_act[DIV_W-1:1] == '0);
    assign w_wrap = (r_cnt == (r_div_act - DIV_W'(1)));

    // Counter and phase. The divider reloads on a wrap, a clear, or while
    // resting, so that a note that follows a rest starts at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_act <= '0;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
        end else if (clear || w_rest) begin
            r_div_act <= div;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
        end else if (w_wrap) begin
            r_div_act <= div;
            r_cnt     <= '0;
            r_phase   <= ~r_phase;
        end else begin
            r_cnt     <= r_cnt + DIV_W'(1);
        end
    end

    assign phase = r_phase;
    assign rest  = w_rest;

endmodule
`default_nettype wire

// File: rtl/tone_synth.sv
`default_nettype none
// ============================================================================
//  Module      : tone_synth
//  Description : Converts note dividers into square waves. It applies a
//                volume level and a 16-step attack/release envelope, and
//                outputs signed 16-bit left and right samples.
//                Build option TONE_SYNTH_STEREO_EN adds an independent right
//                oscillator driven by note_div_r. Without this option,
//                audio_r mirrors audio_l.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_synth
    import audio_pkg::*;
#(
    parameter int ENV_STEP = 2048,
    parameter int DIV_W    = 22
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          mode,
    input  logic [11:0]         ibeat,
    input  logic [DIV_W-1:0]    note_div_l,
    input  logic [DIV_W-1:0]    note_div_r,
    input  logic [2:0]          volume,
    input  logic                mute,
    output logic signed [15:0]  audio_l,
    output logic signed [15:0]  audio_r,
    output logic                note_on
);

    localparam int TMR_W = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;

    env_state_t       r_state, w_state_nxt;
    logic [4:0]       r_env, w_env_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic [3:0]       r_mode_q;
    logic [11:0]      r_ibeat_q;
    logic [DIV_W-1:0] r_div_trig;
    logic             w_mode_ok;
    logic             w_trig;
    logic             w_tick;
    logic             w_osc_clear;
    logic             w_phase_l, w_rest_l;

    assign w_mode_ok   = (mode <= FAILURE);
    // A new beat retriggers only when the note changes. A mode change always retriggers.
    assign w_trig      = (mode != r_mode_q) ||
                         ((ibeat != r_ibeat_q) && (note_div_l != r_div_trig));
    assign w_tick      = (r_tmr == TMR_W'(ENV_STEP - 1));
    assign w_osc_clear = w_trig || !w_mode_ok;

    // Beat, mode and last-retrigger note history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_q   <= '0;
            r_ibeat_q  <= '0;
            r_div_trig <= '0;
        end else begin
            r_mode_q  <= mode;
            r_ibeat_q <= ibeat;
            if (w_trig) begin
                r_div_trig <= note_div_l;
            end
        end
    end

    // Envelope state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ENV_IDLE;
            r_env   <= '0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_env   <= w_env_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // Envelope next state. The step timer defaults to zero, so it
    // restarts on every transition. Priority order is: invalid mode,
    // mute, retrigger, then normal stepping.
    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_tmr_nxt   = '0;
        if (!w_mode_ok) begin
            w_state_nxt = ENV_IDLE;
            w_env_nxt   = '0;
        end else if (mute) begin
            case (r_state)
                ENV_ATTACK, ENV_SUSTAIN: begin
                    // Release from zero has nothing to fade, so go straight to idle
                    w_state_nxt = (r_env == '0) ? ENV_IDLE : ENV_RELEASE;
                end
                ENV_RELEASE: begin
                    if (w_tick) begin
                        w_env_nxt = r_env - 5'd1;
                        if (r_env == 5'd1) begin
                            w_state_nxt = ENV_IDLE;
                        end
                    end else begin
                        w_tmr_nxt = r_tmr + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end else if (w_trig) begin
            w_state_nxt = ENV_ATTACK;
            w_env_nxt   = '0;
        end else begin
            case (r_state)
                ENV_RELEASE: begin
                    // Mute has dropped, so rise again from the current level
                    w_state_nxt = ENV_ATTACK;
                end
                ENV_ATTACK: begin
                    if (w_tick) begin
                        w_env_nxt = r_env + 5'd1;
                        if (r_env == (ENV_MAX - 5'd1)) begin
                            w_state_nxt = ENV_SUSTAIN;
                        end
                    end else begin
                        w_tmr_nxt = r_tmr + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign note_on = (r_state != ENV_IDLE);

    square_osc #(.DIV_W(DIV_W)) u_osc_l (
        .clk     (clk),
        .reset_n (reset_n),
        .div     (note_div_l),
        .clear   (w_osc_clear),
        .phase   (w_phase_l),
        .rest    (w_rest_l)
    );

    // Left sample register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audio_l <= '0;
        end else begin
            audio_l <= square_sample(env_scale(volume, r_env), w_phase_l, !w_mode_ok || w_rest_l);
        end
    end

`ifdef TONE_SYNTH_STEREO_EN
    logic w_phase_r, w_rest_r;

    square_osc #(.DIV_W(DIV_W)) u_osc_r (
        .clk     (clk),
        .reset_n (reset_n),
        .div     (note_div_r),
        .clear   (w_osc_clear),
        .phase   (w_phase_r),
        .rest    (w_rest_r)
    );

    // Right sample register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audio_r <= '0;
        end else begin
            audio_r <= square_sample(env_scale(volume, r_env), w_phase_r, !w_mode_ok || w_rest_r);
        end
    end
`else
    // Mono build: the right channel follows the left channel
    logic w_unused_div_r;
    assign w_unused_div_r = ^note_div_r;
    assign audio_r        = audio_l;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tone_synth.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_synth
//  Description : Self-checking bench for tone_synth. It runs directed
//                scenarios, then randomized stimulus, and compares every
//                cycle against a behavioural model of the synthesizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_synth;

    localparam int STEP = 4;
    localparam int DW   = 22;
`ifdef TONE_SYNTH_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    localparam int S_IDLE = 0, S_ATTACK = 1, S_SUSTAIN = 2, S_RELEASE = 3;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [3:0]         mode = '0;
    logic [11:0]        ibeat = '0;
    logic [DW-1:0]      div_l = '0;
    logic [DW-1:0]      div_r = '0;
    logic [2:0]         volume = '0;
    logic               mute = 1'b0;
    logic signed [15:0] audio_l, audio_r;
    logic               note_on;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_state, m_env, m_tmr, m_modeq, m_ibq, m_divtrig;
    int m_cnt [2];
    int m_ph  [2];
    int m_dact[2];
    int m_al, m_ar;

    always #5 clk = ~clk;

    tone_synth #(.ENV_STEP(STEP), .DIV_W(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .ibeat      (ibeat),
        .note_div_l (div_l),
        .note_div_r (div_r),
        .volume     (volume),
        .mute       (mute),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .note_on    (note_on)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_env = 0; m_tmr = 0;
        m_modeq = 0; m_ibq = 0; m_divtrig = 0;
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = 0; m_ph[c] = 0; m_dact[c] = 0;
        end
        m_al = 0; m_ar = 0;
    endtask

    // Sample value the DUT should register at the next edge
    function automatic int model_sample(int ch);
        int amp;
        if (int'(mode) > 5 || m_dact[ch] < 2) return 0;
        amp = (int'(volume) * 2048 * m_env) / 16;
        return (m_ph[ch] != 0) ? amp : -amp;
    endfunction

    // Advance the model by one clock edge, using the inputs currently applied
    task automatic model_step();
        bit valid, trig;
        int divs[2];
        valid   = (int'(mode) <= 5);
        trig    = (int'(mode) != m_modeq) ||
                  ((int'(ibeat) != m_ibq) && (int'(div_l) != m_divtrig));
        divs[0] = int'(div_l);
        divs[1] = int'(div_r);

        m_al = model_sample(0);
        m_ar = STEREO ? model_sample(1) : m_al;

        for (int c = 0; c < 2; c++) begin
            if (trig || !valid || m_dact[c] < 2) begin
                m_cnt[c] = 0; m_ph[c] = 0; m_dact[c] = divs[c];
            end else if (m_cnt[c] == m_dact[c] - 1) begin
                m_cnt[c] = 0; m_ph[c] = 1 - m_ph[c]; m_dact[c] = divs[c];
            end else begin
                m_cnt[c]++;
            end
        end

        if (!valid) begin
            m_state = S_IDLE; m_env = 0; m_tmr = 0;
        end else if (mute) begin
            if (m_state == S_ATTACK || m_state == S_SUSTAIN) begin
                m_state = (m_env == 0) ? S_IDLE : S_RELEASE;
                m_tmr = 0;
            end else if (m_state == S_RELEASE) begin
                if (m_tmr == STEP - 1) begin
                    m_tmr = 0;
                    m_env--;
                    if (m_env == 0) m_state = S_IDLE;
                end else begin
                    m_tmr++;
                end
            end
        end else if (trig) begin
            m_state = S_ATTACK; m_env = 0; m_tmr = 0;
        end else if (m_state == S_RELEASE) begin
            m_state = S_ATTACK; m_tmr = 0;
        end else if (m_state == S_ATTACK) begin
            if (m_tmr == STEP - 1) begin
                m_tmr = 0;
                m_env++;
                if (m_env == 16) m_state = S_SUSTAIN;
            end else begin
                m_tmr++;
            end
        end

        m_modeq = int'(mode);
        m_ibq   = int'(ibeat);
        if (trig) m_divtrig = int'(div_l);
    endtask

    // Run one clock and compare every output with the model
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check("audio_l", audio_l, m_al);
        check("audio_r", audio_r, m_ar);
        check("note_on", note_on, (m_state != S_IDLE) ? 1 : 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    function automatic int mag(input logic signed [15:0] v);
        int a;
        a = v;
        return (a < 0) ? -a : a;
    endfunction

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        check("rst_async_l", audio_l, 0);
        check("rst_async_r", audio_r, 0);
        check("rst_async_on", note_on, 0);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_l", audio_l, 0);
        check("reset_r", audio_r, 0);
        check("reset_on", note_on, 0);
        reset_n = 1'b1;

        // First note: attack up to full scale at maximum volume
        mode = 4'd1; ibeat = 12'd0; div_l = 22'd5; div_r = 22'd7; volume = 3'd7;
        cyc();
        ibeat = 12'd1;
        run(70);
        check("t1_full_amp", mag(audio_l), 'h3800);
        check("t1_note_on", note_on, 1);

        // Same note on a new beat does not retrigger; a new note does
        ibeat = 12'd2;
        run(10);
        check("t2_tied_amp", mag(audio_l), 'h3800);
        ibeat = 12'd3; div_l = 22'd3;
        run(3);
        check("t2_retrig_low", (mag(audio_l) < 'h3800) ? 1 : 0, 1);
        run(70);

        // Mute releases to silence
        mute = 1'b1;
        run(70);
        check("t3_released_on", note_on, 0);
        check("t3_released_l", audio_l, 0);
        ibeat = 12'd4; div_l = 22'd6;
        cyc();
        check("t3_mute_wins", note_on, 0);
        run(3);
        mute = 1'b0;
        run(3);
        ibeat = 12'd5; div_l = 22'd5;
        run(80);

        // Rest, then a mid-period divider change
        div_l = 22'd1;
        run(20);
        check("t4_rest_zero", audio_l, 0);
        div_l = 22'd5;
        run(7);
        div_l = 22'd9;
        run(40);

        // Mode changes, an invalid mode, and a reset in the middle of a note
        mode = 4'd2;
        run(20);
        mode = 4'd5;
        run(30);
        mode = 4'd7;
        cyc();
        check("t5_bad_mode_l", audio_l, 0);
        check("t5_bad_mode_on", note_on, 0);
        mode = 4'd1;
        run(80);
        reset_pulse();

        // Independent right-channel divider
        ibeat = 12'd6; div_l = 22'd5; div_r = 22'd7;
        run(100);

        // Randomized traffic
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(19, 0) == 0) begin
                ibeat = ibeat + 12'd1;
                if ($urandom_range(1, 0) == 1) div_l = DW'($urandom_range(12, 0));
            end
            if ($urandom_range(29, 0) == 0) div_r = DW'($urandom_range(12, 0));
            if ($urandom_range(49, 0) == 0) volume = 3'($urandom_range(7, 0));
            if ($urandom_range(149, 0) == 0) mute = ~mute;
            if ($urandom_range(299, 0) == 0) mode = 4'($urandom_range(7, 0));
            if (it == 1500) reset_pulse();
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
